matrix_bcd_loader: RTL and testbench

Controller that feeds the on-screen matrix digit array. It accepts binary matrix elements from the multiplier result stream over a valid/ready handshake and converts each to BCD with a sequential double-dabble unit. Converted digits are written into a shadow digit bank. When a full set of elements has been written, the shadow bank is copied to the live digit bus at the next rising edge of vblank, so the display never tears. The live bus drives the per-digit bcd inputs of the digit_8x16 array in vga_rtl_top.

---
 rtl/matrix_bcd_loader.sv | 217 +++++++++++++++++++++
 tb/tb_matrix_bcd_loader.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_bcd_loader.sv
// ---------------------------------------------------------------------------
// matrix_bcd_loader
//
// Feeds the on-screen matrix digit array. Binary matrix elements arrive from
// the multiplier result stream over a valid/ready handshake. Each element is
// converted to BCD by a sequential double-dabble unit, one data bit per cycle,
// and written into a shadow digit bank. Once a complete set of E elements is
// in the shadow bank, the bank is copied to the live digit bus on the next
// rising edge of vblank, so the display never shows a half-updated frame.
//
// Element order on the stream: e = i*(NUM_MAT*MATRIX_M) + j*MATRIX_M + k
// (i = row, j = matrix, k = column). Digit l of element e sits at
// bcd_out[(e*DIGITS+l)*4 +: 4], with l = 0 the most significant digit.
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous, active-low reset
//   s_valid    element valid
//   s_ready    loader can accept an element (registered)
//   s_data     unsigned element value, DATA_W bits
//   vblank     vertical blank, already in the clk domain
//   bcd_out    live digit bus, E*DIGITS*4 bits
//   frame_done one-cycle pulse on the cycle after a bank swap edge
//   overflow   sticky flag, set when an element needed more than DIGITS digits
// ---------------------------------------------------------------------------
module matrix_bcd_loader #(
  parameter int MATRIX_N = 3,
  parameter int MATRIX_M = 3,
  parameter int NUM_MAT  = 3,
  parameter int DIGITS   = 5,
  parameter int DATA_W   = 16
) (
  input  logic                                          clk,
  input  logic                                          reset_n,
  input  logic                                          s_valid,
  output logic                                          s_ready,
  input  logic [DATA_W-1:0]                             s_data,
  input  logic                                          vblank,
  output logic [MATRIX_N*NUM_MAT*MATRIX_M*DIGITS*4-1:0] bcd_out,
  output logic                                          frame_done,
  output logic                                          overflow
);

  localparam int E      = MATRIX_N * NUM_MAT * MATRIX_M;
  localparam int SLOT_W = DIGITS * 4;
  localparam int BUS_W  = E * SLOT_W;

  // Number of decimal digits of 2^DATA_W - 1: floor(DATA_W*log10(2)) + 1.
  // 2^DATA_W is never a power of ten, so this matches 2^DATA_W - 1 exactly.
  localparam int ACC_DIGITS = (DATA_W * 30103) / 100000 + 1;

  // The accumulator is never narrower than one display slot, so the slot
  // digits can always be taken straight from its low nibbles.
  localparam int ACC_NIB = (ACC_DIGITS > DIGITS) ? ACC_DIGITS : DIGITS;
  localparam int ACC_W   = ACC_NIB * 4;

  localparam int CNT_W = (E > 1) ? $clog2(E) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_CONVERT   = 2'd1;
  localparam logic [1:0] ST_STORE     = 2'd2;
  localparam logic [1:0] ST_WAIT_SWAP = 2'd3;

  logic [1:0]        state_q,      state_d;
  logic [DATA_W-1:0] data_q,       data_d;
  logic [ACC_W-1:0]  acc_q,        acc_d;
  logic [BIT_W-1:0]  bit_cnt_q,    bit_cnt_d;
  logic [CNT_W-1:0]  elem_cnt_q,   elem_cnt_d;
  logic [BUS_W-1:0]  shadow_q,     shadow_d;
  logic [BUS_W-1:0]  bcd_out_q,    bcd_out_d;
  logic              s_ready_q,    s_ready_d;
  logic              frame_done_q, frame_done_d;
  logic              overflow_q,   overflow_d;
  logic              vblank_q,     vblank_d;

  logic [ACC_W-1:0]  acc_adj;
  logic [SLOT_W-1:0] slot_digits;
  logic              too_big;
  logic              vblank_rise;

  // Double-dabble correction step: every BCD nibble of 5 or more gets +3 so
  // that the following left shift carries correctly into the next decade.
  always_comb begin
    acc_adj = '0;
    for (int d = 0; d < ACC_NIB; d++) begin
      if (acc_q[d*4 +: 4] >= 4'd5) begin
        acc_adj[d*4 +: 4] = acc_q[d*4 +: 4] + 4'd3;
      end else begin
        acc_adj[d*4 +: 4] = acc_q[d*4 +: 4];
      end
    end
  end

  // Turn the finished accumulator into one display slot. The bus places the
  // most significant digit at the lowest nibble, so the digit order is
  // reversed here. Any nonzero digit above the slot width means the value
  // does not fit; the slot then shows all nines.
  always_comb begin
    too_big     = 1'b0;
    slot_digits = '0;
    for (int d = DIGITS; d < ACC_NIB; d++) begin
      too_big = too_big | (acc_q[d*4 +: 4] != 4'd0);
    end
    for (int l = 0; l < DIGITS; l++) begin
      slot_digits[l*4 +: 4] = acc_q[(DIGITS-1-l)*4 +: 4];
    end
    if (too_big) begin
      slot_digits = {DIGITS{4'h9}};
    end
  end

  // vblank is already synchronous to clk; one register is enough to find
  // its rising edge.
  assign vblank_d    = vblank;
  assign vblank_rise = vblank & ~vblank_q;

  // Main controller. s_ready is registered and simply reflects whether the
  // next state is IDLE, which makes it rise one edge after reset release and
  // fall on the same edge that accepts an element.
  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    acc_d        = acc_q;
    bit_cnt_d    = bit_cnt_q;
    elem_cnt_d   = elem_cnt_q;
    shadow_d     = shadow_q;
    bcd_out_d    = bcd_out_q;
    overflow_d   = overflow_q;
    frame_done_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (s_valid && s_ready_q) begin
          data_d    = s_data;
          acc_d     = '0;
          bit_cnt_d = '0;
          state_d   = ST_CONVERT;
        end
      end

      // One data bit per cycle, MSB first, for exactly DATA_W cycles.
      ST_CONVERT: begin
        acc_d     = (acc_adj << 1) | ACC_W'(data_q[DATA_W-1]);
        data_d    = data_q << 1;
        bit_cnt_d = bit_cnt_q + BIT_W'(1);
        if (bit_cnt_q == BIT_W'(DATA_W - 1)) begin
          state_d = ST_STORE;
        end
      end

      ST_STORE: begin
        shadow_d[int'(elem_cnt_q)*SLOT_W +: SLOT_W] = slot_digits;
        overflow_d = overflow_q | too_big;
        if (elem_cnt_q == CNT_W'(E - 1)) begin
          elem_cnt_d = '0;
          state_d    = ST_WAIT_SWAP;
        end else begin
          elem_cnt_d = elem_cnt_q + CNT_W'(1);
          state_d    = ST_IDLE;
        end
      end

      // A vblank that is already high on entry has vblank_q high too, so
      // only a fresh rising edge triggers the swap.
      ST_WAIT_SWAP: begin
        if (vblank_rise) begin
          bcd_out_d    = shadow_q;
          frame_done_d = 1'b1;
          state_d      = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    s_ready_d = (state_d == ST_IDLE);
  end

  // State registers. Reset aborts any conversion or pending swap and clears
  // both digit banks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      data_q       <= '0;
      acc_q        <= '0;
      bit_cnt_q    <= '0;
      elem_cnt_q   <= '0;
      shadow_q     <= '0;
      bcd_out_q    <= '0;
      s_ready_q    <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      vblank_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      acc_q        <= acc_d;
      bit_cnt_q    <= bit_cnt_d;
      elem_cnt_q   <= elem_cnt_d;
      shadow_q     <= shadow_d;
      bcd_out_q    <= bcd_out_d;
      s_ready_q    <= s_ready_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
      vblank_q     <= vblank_d;
    end
  end

  assign s_ready    = s_ready_q;
  assign bcd_out    = bcd_out_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_matrix_bcd_loader.sv
// ---------------------------------------------------------------------------
// tb_matrix_bcd_loader
//
// Drives two loaders from the same stream: a default instance (5 digits per
// element) and a 4-digit instance that saturates on values above 9999.
// Table-driven frame checks plus hand-written sequences for reset, latency,
// vblank timing and mid-operation reset.
// ---------------------------------------------------------------------------
module tb_matrix_bcd_loader;

  localparam int E     = 27;
  localparam int BUS_5 = E * 5 * 4;
  localparam int BUS_4 = E * 4 * 4;

  logic             clk;
  logic             reset_n;
  logic             s_valid;
  logic [15:0]      s_data;
  logic             vblank;
  logic             s_ready_5, s_ready_4;
  logic             frame_done_5, frame_done_4;
  logic             overflow_5, overflow_4;
  logic [BUS_5-1:0] bcd_5;
  logic [BUS_4-1:0] bcd_4;

  typedef struct packed {
    logic [15:0] value;
    logic [19:0] exp_nat;
  } vec_t;

  vec_t        table_v   [E];
  logic [15:0] frame_vals[E];
  logic [19:0] exp5_arr  [E];
  logic [15:0] exp4_arr  [E];

  int pass_count  = 0;
  int check_count = 0;
  int cycle       = 0;
  int fd_count_5  = 0;

  matrix_bcd_loader dut5 (
    .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_ready(s_ready_5),
    .s_data(s_data), .vblank(vblank), .bcd_out(bcd_5),
    .frame_done(frame_done_5), .overflow(overflow_5)
  );

  matrix_bcd_loader #(.DIGITS(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_ready(s_ready_4),
    .s_data(s_data), .vblank(vblank), .bcd_out(bcd_4),
    .frame_done(frame_done_4), .overflow(overflow_4)
  );

  // Clock, cycle counter and frame_done pulse counter (sampled 2 ns after
  // each rising edge so reads at the falling edge never race).
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cycle++;
    #2;
    if (frame_done_5) fd_count_5++;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: actual %0h, expected %0h", name, actual, expected);
  endtask

  // Reference slot in bus layout: MSB digit at nibble 0, saturating to nines.
  function automatic logic [19:0] busSlot(input int v, input int nd);
    logic [19:0] r;
    int x, lim;
    r = '0;
    x = v;
    lim = 1;
    for (int i = 0; i < nd; i++) lim = lim * 10;
    if (v >= lim) begin
      for (int l = 0; l < nd; l++) r[l*4 +: 4] = 4'h9;
      return r;
    end
    for (int l = nd - 1; l >= 0; l--) begin
      r[l*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Natural-reading BCD (least significant digit lowest) to bus layout.
  function automatic logic [19:0] revNib(input logic [19:0] x, input int n);
    logic [19:0] r;
    r = '0;
    for (int l = 0; l < n; l++) r[l*4 +: 4] = x[(n-1-l)*4 +: 4];
    return r;
  endfunction

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Offer one element (called at a falling edge) and wait for the handshake.
  task automatic applyStimulus(input logic [15:0] value, input bit hold_valid,
                               output int accept_cycle);
    bit done;
    done = 1'b0;
    accept_cycle = -1;
    s_valid = 1'b1;
    s_data  = value;
    for (int w = 0; w < 200 && !done; w++) begin
      if (s_ready_5) begin
        @(posedge clk);
        @(negedge clk);
        accept_cycle = cycle;
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) checkOutput("accept timeout", 64'd0, 64'd1);
    if (!hold_valid) s_valid = 1'b0;
    s_data = 16'($urandom);
  endtask

  task automatic sendRange(input int first, input int last,
                           output int min_gap, output int max_gap);
    int prev, acc_cyc;
    min_gap = 1000000;
    max_gap = 0;
    prev    = -1;
    for (int e = first; e <= last; e++) begin
      applyStimulus(frame_vals[e], 1'b1, acc_cyc);
      if (prev >= 0) begin
        if (acc_cyc - prev < min_gap) min_gap = acc_cyc - prev;
        if (acc_cyc - prev > max_gap) max_gap = acc_cyc - prev;
      end
      prev = acc_cyc;
    end
    s_valid = 1'b0;
  endtask

  task automatic modelFrame();
    for (int e = 0; e < E; e++) begin
      exp5_arr[e] = busSlot(int'(frame_vals[e]), 5);
      exp4_arr[e] = busSlot(int'(frame_vals[e]), 4)[15:0];
    end
  endtask

  task automatic checkFrame(input string tag);
    for (int e = 0; e < E; e++) begin
      checkOutput($sformatf("%s slot5 %0d", tag, e), bcd_5[e*20 +: 20], exp5_arr[e]);
      checkOutput($sformatf("%s slot4 %0d", tag, e), bcd_4[e*16 +: 16], exp4_arr[e]);
    end
  endtask

  // Raise vblank at a falling edge and check the swap pulse on both sides.
  task automatic swapAndCheck(input string tag);
    vblank = 1'b1;
    @(negedge clk);
    checkOutput({tag, " frame_done high"}, frame_done_5, 1'b1);
    @(negedge clk);
    checkOutput({tag, " frame_done one cycle"}, frame_done_5, 1'b0);
    vblank = 1'b0;
    settle(2);
  endtask

  initial begin
    int min_gap, max_gap, acc_cyc, ready_err, fd_before;

    table_v[0]  = '{16'd0,     20'h00000};
    table_v[1]  = '{16'd9,     20'h00009};
    table_v[2]  = '{16'd10,    20'h00010};
    table_v[3]  = '{16'd99,    20'h00099};
    table_v[4]  = '{16'd100,   20'h00100};
    table_v[5]  = '{16'd255,   20'h00255};
    table_v[6]  = '{16'd1000,  20'h01000};
    table_v[7]  = '{16'd4095,  20'h04095};
    table_v[8]  = '{16'd9999,  20'h09999};
    table_v[9]  = '{16'd10000, 20'h10000};
    table_v[10] = '{16'd12345, 20'h12345};
    table_v[11] = '{16'd54321, 20'h54321};
    table_v[12] = '{16'd65535, 20'h65535};
    table_v[13] = '{16'd32768, 20'h32768};
    table_v[14] = '{16'd50000, 20'h50000};
    table_v[15] = '{16'd59999, 20'h59999};
    table_v[16] = '{16'd1,     20'h00001};
    table_v[17] = '{16'd7,     20'h00007};
    table_v[18] = '{16'd42,    20'h00042};
    table_v[19] = '{16'd500,   20'h00500};
    table_v[20] = '{16'd808,   20'h00808};
    table_v[21] = '{16'd1234,  20'h01234};
    table_v[22] = '{16'd5555,  20'h05555};
    table_v[23] = '{16'd8191,  20'h08191};
    table_v[24] = '{16'd2048,  20'h02048};
    table_v[25] = '{16'd39,    20'h00039};
    table_v[26] = '{16'd777,   20'h00777};

    reset_n = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    vblank  = 1'b0;

    // Reset state.
    settle(3);
    checkOutput("reset s_ready", s_ready_5, 1'b0);
    checkOutput("reset bcd5 zero", bcd_5 == '0, 1'b1);
    checkOutput("reset bcd4 zero", bcd_4 == '0, 1'b1);
    checkOutput("reset overflow", overflow_5, 1'b0);
    checkOutput("reset frame_done", frame_done_5, 1'b0);
    reset_n = 1'b1;
    #1;
    checkOutput("s_ready before first edge", s_ready_5, 1'b0);
    @(negedge clk);
    checkOutput("s_ready after first edge", s_ready_5, 1'b1);
    $display("[TB] reset checks done");

    // 12345 then 26 zeros; exact ready timing for the first element.
    s_valid = 1'b1;
    s_data  = 16'd12345;
    @(posedge clk);
    ready_err = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 0) begin
        s_valid = 1'b0;
        s_data  = 16'hFFFF;
      end
      if (s_ready_5 !== (k >= 17)) ready_err++;
    end
    checkOutput("s_ready latency trace errors", 64'(ready_err), 64'd0);
    for (int e = 1; e < E; e++) frame_vals[e] = 16'd0;
    sendRange(1, E - 1, min_gap, max_gap);
    checkOutput("accept interval min", 64'(min_gap), 64'd18);
    checkOutput("accept interval max", 64'(max_gap), 64'd18);
    settle(30);
    checkOutput("waiting s_ready low", s_ready_5, 1'b0);
    checkOutput("no swap before vblank", bcd_5 == '0, 1'b1);
    fd_before = fd_count_5;
    swapAndCheck("frame1");
    checkOutput("frame1 slot0", bcd_5[19:0], 20'h54321);
    checkOutput("frame1 rest zero", bcd_5[BUS_5-1:20] == '0, 1'b1);
    checkOutput("frame1 single pulse", 64'(fd_count_5 - fd_before), 64'd1);
    checkOutput("frame1 s_ready after swap", s_ready_5, 1'b1);
    checkOutput("dig4 saturated slot0", bcd_4[15:0], 16'h9999);
    checkOutput("dig4 overflow set", overflow_4, 1'b1);
    checkOutput("dig5 overflow clear", overflow_5, 1'b0);

    // Table-driven frame with hand-computed digits.
    for (int e = 0; e < E; e++) begin
      frame_vals[e] = table_v[e].value;
      exp5_arr[e]   = revNib(table_v[e].exp_nat, 5);
      exp4_arr[e]   = (table_v[e].value > 16'd9999) ? 16'h9999
                                                    : revNib(table_v[e].exp_nat, 4)[15:0];
    end
    sendRange(0, E - 1, min_gap, max_gap);
    settle(20);
    swapAndCheck("table");
    checkFrame("table");
    checkOutput("table overflow5", overflow_5, 1'b0);
    checkOutput("table overflow4", overflow_4, 1'b1);

    // Stream 0..26; overflow on the 4-digit instance stays set.
    for (int e = 0; e < E; e++) frame_vals[e] = 16'(e);
    modelFrame();
    sendRange(0, E - 1, min_gap, max_gap);
    settle(20);
    swapAndCheck("ramp");
    checkFrame("ramp");
    checkOutput("ramp element 26", bcd_5[539:520], 20'h62000);
    checkOutput("overflow4 sticky", overflow_4, 1'b1);

    // vblank already high when the last element stores.
    for (int e = 0; e < E; e++) frame_vals[e] = 16'(1000 + e * 7);
    sendRange(0, E - 2, min_gap, max_gap);
    vblank = 1'b1;
    settle(3);
    sendRange(E - 1, E - 1, min_gap, max_gap);
    fd_before = fd_count_5;
    settle(40);
    checkOutput("held vblank no pulse", 64'(fd_count_5 - fd_before), 64'd0);
    checkOutput("held vblank s_ready", s_ready_5, 1'b0);
    checkOutput("held vblank old e26", bcd_5[539:520], 20'h62000);
    vblank = 1'b0;
    settle(3);
    checkOutput("vblank fall no swap", bcd_5[539:520], 20'h62000);
    modelFrame();
    fd_before = fd_count_5;
    swapAndCheck("late");
    checkFrame("late");
    checkOutput("late single pulse", 64'(fd_count_5 - fd_before), 64'd1);

    // Reset with a swap pending.
    for (int e = 0; e < E; e++) frame_vals[e] = 16'(300 + e);
    sendRange(0, E - 1, min_gap, max_gap);
    settle(20);
    reset_n = 1'b0;
    #1;
    checkOutput("pending reset bcd5", bcd_5 == '0, 1'b1);
    checkOutput("pending reset bcd4", bcd_4 == '0, 1'b1);
    checkOutput("pending reset overflow4", overflow_4, 1'b0);
    checkOutput("pending reset s_ready", s_ready_5, 1'b0);
    settle(2);
    reset_n = 1'b1;
    settle(2);
    checkOutput("after reset s_ready", s_ready_5, 1'b1);
    fd_before = fd_count_5;
    vblank = 1'b1;
    settle(3);
    vblank = 1'b0;
    settle(2);
    checkOutput("swap dropped by reset", 64'(fd_count_5 - fd_before), 64'd0);
    checkOutput("bcd stays zero", bcd_5 == '0, 1'b1);

    // Reset in the middle of converting element 5.
    for (int e = 0; e < E; e++) frame_vals[e] = 16'(500 + e);
    sendRange(0, 4, min_gap, max_gap);
    applyStimulus(16'd505, 1'b0, acc_cyc);
    settle(5);
    reset_n = 1'b0;
    #1;
    checkOutput("mid convert s_ready", s_ready_5, 1'b0);
    settle(2);
    reset_n = 1'b1;
    settle(2);
    for (int e = 0; e < E; e++) frame_vals[e] = 16'(600 + e);
    modelFrame();
    sendRange(0, E - 1, min_gap, max_gap);
    settle(20);
    swapAndCheck("restart");
    checkFrame("restart");
    checkOutput("restart overflow4", overflow_4, 1'b0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
